// File: rtl/vga_scan_if.sv
// Scan-controller bus: run request in, counters/qualifiers/syncs out.
// game_tick_o exists only when VGA_SCAN_GAME_TICK_EN is defined.
interface vga_scan_if #(
  parameter int CNT_W = 10
);
  logic             enable_i;
  logic [CNT_W-1:0] x_o;
  logic [CNT_W-1:0] y_o;
  logic             display_enable_o;
  logic             hsync_o;
  logic             vsync_o;
  logic             frame_start_o;
  logic             frame_end_o;
  logic             busy_o;
`ifdef VGA_SCAN_GAME_TICK_EN
  logic             game_tick_o;
`endif

  modport slave (
    input  enable_i,
    output x_o, y_o, display_enable_o, hsync_o, vsync_o,
           frame_start_o, frame_end_o, busy_o
`ifdef VGA_SCAN_GAME_TICK_EN
    , output game_tick_o
`endif
  );

  modport master (
    output enable_i,
    input  x_o, y_o, display_enable_o, hsync_o, vsync_o,
           frame_start_o, frame_end_o, busy_o
`ifdef VGA_SCAN_GAME_TICK_EN
    , input game_tick_o
`endif
  );
endinterface

// File: rtl/vga_scan_ctrl.sv
// Pixel-clock scan controller: h/v counters, display qualifier, pipelined syncs, frame pulses.
// Optional frame-divided game tick enabled by defining VGA_SCAN_GAME_TICK_EN.
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CNT_W    = 10,
  parameter int PIPE_DLY = 2,
  parameter int SYNC_POL = 0
`ifdef VGA_SCAN_GAME_TICK_EN
  , parameter int TICK_DIV = 8
`endif
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  vga_scan_if.slave  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic             ACT    = (SYNC_POL != 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] h_q, v_q;
  logic [CNT_W-1:0] h_d, v_d;
  logic             h_last, v_last, busy;
  logic             raw_hs, raw_vs;
  logic             frame_end;

  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);
  assign busy   = (state_q != S_IDLE);

  always_comb begin
    h_d = h_last ? '0 : h_q + CNT_W'(1);
    v_d = v_q;
    if (h_last) v_d = v_last ? '0 : v_q + CNT_W'(1);
  end

  // STOPPING keeps scanning until the frame completes, so a re-enable is seamless.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          h_q <= '0;
          v_q <= '0;
          if (bus.enable_i) state_q <= S_RUN;
        end
        S_RUN: begin
          h_q <= h_d;
          v_q <= v_d;
          if (!bus.enable_i) state_q <= S_STOP;
        end
        S_STOP: begin
          h_q <= h_d;
          v_q <= v_d;
          if (bus.enable_i)         state_q <= S_RUN;
          else if (h_last && v_last) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          h_q     <= '0;
          v_q     <= '0;
        end
      endcase
    end
  end

  assign frame_end = busy && h_last && v_last;

  assign bus.x_o              = h_q;
  assign bus.y_o              = v_q;
  assign bus.busy_o           = busy;
  assign bus.display_enable_o = busy && (h_q < H_ACT) && (v_q < V_ACT);
  assign bus.frame_start_o    = busy && (h_q == '0) && (v_q == '0);
  assign bus.frame_end_o      = frame_end;

  assign raw_hs = (busy && h_q >= HS_BEG && h_q <= HS_END) ? ACT : ~ACT;
  assign raw_vs = (busy && v_q >= VS_BEG && v_q <= VS_END) ? ACT : ~ACT;

  // Sync delay line matches gfx+drawer latency; it drains naturally after IDLE entry.
  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign bus.hsync_o = raw_hs;
      assign bus.vsync_o = raw_vs;
    end else begin : g_dly
      logic [PIPE_DLY-1:0] hs_pipe_q, vs_pipe_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          hs_pipe_q <= {PIPE_DLY{~ACT}};
          vs_pipe_q <= {PIPE_DLY{~ACT}};
        end else begin
          hs_pipe_q[0] <= raw_hs;
          vs_pipe_q[0] <= raw_vs;
          for (int i = 1; i < PIPE_DLY; i++) begin
            hs_pipe_q[i] <= hs_pipe_q[i-1];
            vs_pipe_q[i] <= vs_pipe_q[i-1];
          end
        end
      end
      assign bus.hsync_o = hs_pipe_q[PIPE_DLY-1];
      assign bus.vsync_o = vs_pipe_q[PIPE_DLY-1];
    end
  endgenerate

`ifdef VGA_SCAN_GAME_TICK_EN
  localparam int             TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]  DIV_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] div_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                div_q <= '0;
    else if (state_q == S_IDLE) div_q <= '0;
    else if (frame_end)         div_q <= (div_q == DIV_LAST) ? '0 : div_q + TW'(1);
  end

  assign bus.game_tick_o = frame_end && (div_q == DIV_LAST);
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboarded bench for vga_scan_ctrl on a shrunken timing (15x8 frame) to keep runs short.
module tb_vga_scan_ctrl;
  localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
  localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int CNT_W = 10, PIPE_DLY = 2, TD = 3;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_scan_if #(.CNT_W(CNT_W)) bus ();

  vga_scan_ctrl #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CNT_W(CNT_W), .PIPE_DLY(PIPE_DLY), .SYNC_POL(0)
`ifdef VGA_SCAN_GAME_TICK_EN
    , .TICK_DIV(TD)
`endif
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    int x, y, de, hs, vs, fs, fe, busy, tk;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_bad = 0;

  // reference model: ms 0=idle 1=run 2=stopping; mfr = frames completed this session
  int ms, mh, mv, mfr;
  bit ph[PIPE_DLY], pv[PIPE_DLY];

  // observation counters, cleared by the sequence
  int cnt_fe, cnt_fs, cnt_tk, cnt_hs_lo, cnt_vs_lo, first_hs_x;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    ms = 0; mh = 0; mv = 0; mfr = 0;
    for (int i = 0; i < PIPE_DLY; i++) begin ph[i] = 1'b1; pv[i] = 1'b1; end
  endtask

  task automatic madv();
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else mh++;
  endtask

  task automatic mstep();
    bit en, busy, rh, rv, fe_old;
    if (!rst_n) begin mreset(); return; end
    en     = bus.enable_i;
    busy   = (ms != 0);
    rh     = !(busy && mh >= H_ACTIVE + H_FP && mh < H_ACTIVE + H_FP + H_SYNC);
    rv     = !(busy && mv >= V_ACTIVE + V_FP && mv < V_ACTIVE + V_FP + V_SYNC);
    for (int i = PIPE_DLY - 1; i > 0; i--) begin ph[i] = ph[i-1]; pv[i] = pv[i-1]; end
    ph[0]  = rh;
    pv[0]  = rv;
    fe_old = busy && mh == HT - 1 && mv == VT - 1;
    if (!busy) mfr = 0;
    else if (fe_old) mfr++;
    case (ms)
      0: if (en) ms = 1;
      1: begin madv(); if (!en) ms = 2; end
      default: begin
        if (en) ms = 1;
        else if (fe_old) ms = 0;
        madv();
      end
    endcase
  endtask

  function automatic exp_t mexp();
    exp_t e;
    bit b = (ms != 0);
    e.x    = mh;
    e.y    = mv;
    e.busy = b;
    e.de   = b && mh < H_ACTIVE && mv < V_ACTIVE;
    e.hs   = ph[PIPE_DLY-1];
    e.vs   = pv[PIPE_DLY-1];
    e.fs   = b && mh == 0 && mv == 0;
    e.fe   = b && mh == HT - 1 && mv == VT - 1;
    e.tk   = e.fe && ((mfr + 1) % TD == 0);
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    mstep();
    exp_q.push_back(mexp());
    @(negedge clk);
    e = exp_q.pop_front();
    chk("x",    bus.x_o, e.x);
    chk("y",    bus.y_o, e.y);
    chk("de",   bus.display_enable_o, e.de);
    chk("hs",   bus.hsync_o, e.hs);
    chk("vs",   bus.vsync_o, e.vs);
    chk("fs",   bus.frame_start_o, e.fs);
    chk("fe",   bus.frame_end_o, e.fe);
    chk("busy", bus.busy_o, e.busy);
`ifdef VGA_SCAN_GAME_TICK_EN
    chk("tick", bus.game_tick_o, e.tk);
    cnt_tk += int'(bus.game_tick_o);
`endif
    cnt_fe += int'(bus.frame_end_o);
    cnt_fs += int'(bus.frame_start_o);
    if (bus.hsync_o == 1'b0) begin
      if (cnt_hs_lo == 0) first_hs_x = int'(bus.x_o);
      cnt_hs_lo++;
    end
    if (bus.vsync_o == 1'b0) cnt_vs_lo++;
  endtask

  task automatic clr();
    cnt_fe = 0; cnt_fs = 0; cnt_tk = 0; cnt_hs_lo = 0; cnt_vs_lo = 0; first_hs_x = -1;
  endtask

  task automatic run_until(int h, int v);
    bit hit = 1'b0;
    for (int i = 0; i < 3 * FT && !hit; i++) begin
      tick();
      hit = (int'(bus.x_o) == h) && (int'(bus.y_o) == v) && bus.busy_o;
    end
    chk("run_until_to", hit, 1);
  endtask

  task automatic wait_idle();
    bit hit = 1'b0;
    for (int i = 0; i < 3 * FT && !hit; i++) begin
      tick();
      hit = !bus.busy_o;
    end
    chk("idle_to", hit, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.enable_i = 1'b0;
    mreset();
    clr();
    repeat (3) tick();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_hs", bus.hsync_o, 1);
    rst_n = 1'b1;
    repeat (3) tick();

    // first RUN cycle and one full line of hsync
    bus.enable_i = 1'b1;
    tick();
    chk("first_x", bus.x_o, 0);
    chk("first_de", bus.display_enable_o, 1);
    chk("first_fs", bus.frame_start_o, 1);
    clr();
    repeat (HT) tick();
    chk("hs_len", cnt_hs_lo, H_SYNC);
    chk("hs_first_x", first_hs_x, H_ACTIVE + H_FP + PIPE_DLY);
    clr();
    repeat (FT) tick();
    chk("vs_len", cnt_vs_lo, V_SYNC * HT);

    // asynchronous reset while hsync output is asserted
    run_until(H_ACTIVE + H_FP + PIPE_DLY + 1, 1);
    chk("pre_rst_hs", bus.hsync_o, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", bus.x_o, 0);
    chk("arst_de", bus.display_enable_o, 0);
    chk("arst_hs", bus.hsync_o, 1);
    chk("arst_vs", bus.vsync_o, 1);
    chk("arst_busy", bus.busy_o, 0);
    mreset();
    exp_q.delete();
    bus.enable_i = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // stop mid-frame: finish the frame, then idle with no new frame_start
    bus.enable_i = 1'b1;
    run_until(0, 2);
    bus.enable_i = 1'b0;
    clr();
    wait_idle();
    chk("stop_fe", cnt_fe, 1);
    repeat (5) tick();
    chk("stop_fs", cnt_fs, 0);

    // drop and re-enable within a frame: seamless continuation
    bus.enable_i = 1'b1;
    run_until(0, 2);
    bus.enable_i = 1'b0;
    run_until(0, 5);
    bus.enable_i = 1'b1;
    clr();
    run_until(0, 0);
    chk("resume_fs", bus.frame_start_o, 1);
    chk("resume_fe", cnt_fe, 1);
    bus.enable_i = 1'b0;
    wait_idle();

`ifdef VGA_SCAN_GAME_TICK_EN
    bus.enable_i = 1'b1;
    clr();
    repeat (7 * FT) tick();
    chk("tick_cnt", cnt_tk, 2);
    bus.enable_i = 1'b0;
    wait_idle();
    bus.enable_i = 1'b1;
    clr();
    repeat (3 * FT) tick();
    chk("tick_restart", cnt_tk, 1);
    bus.enable_i = 1'b0;
    wait_idle();
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
